// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB first,
// repeated reps times with gap idle cycles between repetitions.
module seq_pattern_tx #(
   parameter int WIDTH = 4,
   parameter int REPW  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   input  logic [REPW-1:0]  reps,
   input  logic [REPW-1:0]  gap,
   output logic             out,
   output logic             out_valid,
   output logic             busy,
   output logic             done
);

   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] MSB_IDX = IW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_d;

   logic [WIDTH-1:0] pat_q, pat_d;
   logic [REPW-1:0]  reps_q, reps_d;
   logic [REPW-1:0]  gap_q, gap_d;
   logic [REPW-1:0]  gap_cnt_q, gap_cnt_d;
   logic [IW-1:0]    bit_idx_q, bit_idx_d;
   logic             out_q, out_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      state_d   = state;
      pat_d     = pat_q;
      reps_d    = reps_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      bit_idx_d = bit_idx_q;
      out_d     = 1'b0;
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      done_d    = 1'b0;

      if (abort) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  if (reps != '0) begin
                     pat_d     = pattern;
                     reps_d    = reps;
                     gap_d     = gap;
                     bit_idx_d = MSB_IDX;
                     state_d   = SEND;
                     out_d     = pattern[WIDTH-1];
                     valid_d   = 1'b1;
                     busy_d    = 1'b1;
                  end else begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end
               end
            end

            SEND: begin
               if (bit_idx_q != '0) begin
                  bit_idx_d = bit_idx_q - 1'b1;
                  out_d     = pat_q[bit_idx_d];
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  // LSB is on the wire now: one repetition completes this cycle
                  reps_d = reps_q - 1'b1;
                  if (reps_q == REPW'(1)) begin
                     state_d = DONE;
                     done_d  = 1'b1;
                  end else if (gap_q == '0) begin
                     bit_idx_d = MSB_IDX;
                     out_d     = pat_q[WIDTH-1];
                     valid_d   = 1'b1;
                     busy_d    = 1'b1;
                  end else begin
                     state_d   = GAP;
                     gap_cnt_d = gap_q;
                     busy_d    = 1'b1;
                  end
               end
            end

            GAP: begin
               if (gap_cnt_q == REPW'(1)) begin
                  state_d   = SEND;
                  bit_idx_d = MSB_IDX;
                  out_d     = pat_q[WIDTH-1];
                  valid_d   = 1'b1;
                  busy_d    = 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q - 1'b1;
                  busy_d    = 1'b1;
               end
            end

            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pat_q     <= '0;
         reps_q    <= '0;
         gap_q     <= '0;
         gap_cnt_q <= '0;
         bit_idx_q <= '0;
         out_q     <= 1'b0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_d;
         pat_q     <= pat_d;
         reps_q    <= reps_d;
         gap_q     <= gap_d;
         gap_cnt_q <= gap_cnt_d;
         bit_idx_q <= bit_idx_d;
         out_q     <= out_d;
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign out       = out_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: a driver pushes expected output events
// built from a per-transmission timeline; a negedge monitor consumes them.
module tb_seq_pattern_tx;

   localparam int W  = 4;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [W-1:0]  pattern;
   logic [RW-1:0] reps;
   logic [RW-1:0] gap;
   logic          out;
   logic          out_valid;
   logic          busy;
   logic          done;

   seq_pattern_tx #(.WIDTH(W), .REPW(RW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .pattern   (pattern),
      .reps      (reps),
      .gap       (gap),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      bit b;
      int gap_before;
      int busy_total;
   } ev_t;

   typedef struct {
      bit         v;
      bit         b;
      bit         bz;
      bit         dn;
      logic [1:0] st;
   } tl_t;

   ev_t exp_q[$];
   int  tests   = 0;
   int  fails   = 0;
   int  det_cnt = 0;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- monitor ----------------
   int         gap_run  = 0;
   int         busy_run = 0;
   int         hcnt     = 0;
   logic [3:0] hist     = 4'b0;
   ev_t        mon_e;

   always @(negedge clk) begin
      if (out_valid || done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            if (mon_e.is_done) begin
               check("done_event", int'(done), 1);
               check("busy_total", busy_run, mon_e.busy_total);
            end else begin
               check("valid_event", int'(out_valid), 1);
               check("out_bit", int'(out), int'(mon_e.b));
               check("gap_len", gap_run, mon_e.gap_before);
            end
         end
         gap_run = 0;
      end else if (busy) begin
         gap_run++;
      end else begin
         gap_run = 0;
      end
      busy_run = busy ? busy_run + 1 : 0;

      if (!out_valid) check("out_zero_when_invalid", int'(out), 0);
      if (out_valid)  check("busy_with_valid", int'(busy), 1);
      if (done)       check("busy_low_at_done", int'(busy), 0);

      // behavioural 1011 detector fed by the valid serial stream
      if (out_valid) begin
         hist = {hist[2:0], out};
         if (hcnt < 4) hcnt++;
         if (hcnt >= 4 && hist == 4'b1011) det_cnt++;
      end else begin
         hcnt = 0;
      end
   end

   // ---------------- reference model ----------------
   task automatic build_timeline(input logic [W-1:0] pat, input int nreps, input int ngap,
                                 output tl_t tl[$]);
      tl_t t;
      tl = {};
      for (int r = 0; r < nreps; r++) begin
         for (int i = W - 1; i >= 0; i--) begin
            t = '{v: 1'b1, b: pat[i], bz: 1'b1, dn: 1'b0, st: 2'd1};
            tl.push_back(t);
         end
         if (r < nreps - 1) begin
            for (int g = 0; g < ngap; g++) begin
               t = '{v: 1'b0, b: 1'b0, bz: 1'b1, dn: 1'b0, st: 2'd2};
               tl.push_back(t);
            end
         end
      end
      t = '{v: 1'b0, b: 1'b0, bz: 1'b0, dn: 1'b1, st: 2'd3};
      tl.push_back(t);
   endtask

   task automatic push_events(input tl_t tl[$], input int k, input int total);
      int  g_acc;
      ev_t e;
      g_acc = 0;
      for (int c = 0; c < k; c++) begin
         if (tl[c].v) begin
            e = '{is_done: 1'b0, b: tl[c].b, gap_before: g_acc, busy_total: 0};
            exp_q.push_back(e);
            g_acc = 0;
         end else if (tl[c].dn) begin
            e = '{is_done: 1'b1, b: 1'b0, gap_before: 0, busy_total: total};
            exp_q.push_back(e);
         end else begin
            g_acc++;
         end
      end
   endtask

   function automatic int busy_total(input int nreps, input int ngap);
      return (nreps == 0) ? 0 : nreps * W + (nreps - 1) * ngap;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_state"}, int'(dut.state), 0);
      check({tag, "_out"}, int'(out), 0);
      check({tag, "_valid"}, int'(out_valid), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_done"}, int'(done), 0);
   endtask

   // disturb: 0 none, 1 re-pulse start with pattern 0000, 2 random input churn
   task automatic run_txn(input logic [W-1:0] pat, input int nreps, input int ngap,
                          input int k_abort, input int disturb);
      tl_t tl[$];
      int  L;
      int  k;
      build_timeline(pat, nreps, ngap, tl);
      L = tl.size();
      k = (k_abort < 0) ? L : k_abort;
      $display("[TB] txn pattern=%b reps=%0d gap=%0d abort_at=%0d disturb=%0d",
               pat, nreps, ngap, k_abort, disturb);
      push_events(tl, k, busy_total(nreps, ngap));

      pattern = pat;
      reps    = RW'(nreps);
      gap     = RW'(ngap);
      start   = 1'b1;
      abort   = (k == 0);
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;

      for (int c = 0; c < k; c++) begin
         check("state_trace", int'(dut.state), int'(tl[c].st));
         if (disturb == 1) begin
            start   = 1'b1;
            pattern = '0;
         end else if (disturb == 2) begin
            start   = 1'($urandom_range(0, 1));
            pattern = W'($urandom);
            reps    = RW'($urandom);
            gap     = RW'($urandom);
         end
         if (c == k - 1 && k < L) abort = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         abort = 1'b0;
      end
      check_idle("after_txn");
      @(posedge clk); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      tl_t tl[$];
      int  det_before;
      int  nreps;
      int  ngap;
      int  L;
      int  k;

      rst     = 1'b1;
      start   = 1'b0;
      abort   = 1'b0;
      pattern = '0;
      reps    = '0;
      gap     = '0;
      #1;
      check_idle("reset");
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      check_idle("post_reset");

      run_txn(4'b1011, 1, 0, -1, 0);                // single rep, back-to-back done
      run_txn(4'b1011, 2, 2, -1, 0);                // two reps with two-cycle gap
      run_txn(4'b1011, 0, 0, -1, 0);                // reps=0 goes straight to DONE
      run_txn(4'b1011, 3, 1, W + 1 + 2, 0);         // abort on 2nd bit of 2nd rep
      @(posedge clk); #1;
      run_txn(4'b1101, 1, 0, -1, 0);
      run_txn(4'b1011, 1, 0, -1, 1);                // start re-pulse, pattern changed
      run_txn(4'b0110, 2, 0, 0, 0);                 // abort beats simultaneous start
      run_txn(4'b1001, 3, 0, -1, 2);                // back-to-back reps with churn

      // asynchronous reset in the middle of a gap, then start on first edge after release
      det_before = det_cnt;
      build_timeline(4'b1011, 3, 3, tl);
      $display("[TB] txn pattern=1011 reps=3 gap=3 reset during gap");
      push_events(tl, 6, busy_total(3, 3));
      pattern = 4'b1011;
      reps    = 4'd3;
      gap     = 4'd3;
      start   = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("gap_state_before_rst", int'(dut.state), 2);
      check("gap_busy_before_rst", int'(busy), 1);
      #2 rst = 1'b1;
      #1;
      check_idle("async_rst");
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      check("reset_det_count", det_cnt - det_before, 1);
      check("reset_queue_drained", exp_q.size(), 0);
      run_txn(4'b1011, 1, 0, -1, 0);

      for (int n = 0; n < 40; n++) begin
         nreps = $urandom_range(0, 4);
         ngap  = $urandom_range(0, 3);
         L     = busy_total(nreps, ngap) + 1;
         k     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, L - 1) : -1;
         run_txn(W'($urandom), nreps, ngap, k, $urandom_range(0, 2));
      end

      repeat (4) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the pattern length in bits (legal range 2..16).
REQ-002 The block SHALL have parameter REPW, default 4, giving the width of the reps and gap inputs.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 The block SHALL have port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-006 The block SHALL have port abort  input  1  synchronous cancel of any transmission in progress.
REQ-007 The block SHALL have port pattern  input  WIDTH  bit pattern to serialize, MSB first.
REQ-008 The block SHALL have port reps  input  REPW  number of pattern repetitions to send.
REQ-009 The block SHALL have port gap  input  REPW  idle cycles between repetitions.
REQ-010 The block SHALL have port out  output  1  serial data bit, registered.
REQ-011 The block SHALL have port out_valid  output  1  high when out carries a pattern bit, registered.
REQ-012 The block SHALL have port busy  output  1  high from the first transmitted bit through the last, registered.
REQ-013 The block SHALL have port done  output  1  one-cycle completion pulse, registered.

Function
REQ-014 The block SHALL implement a 2-bit register named state, encoded IDLE=0, SEND=1, GAP=2, DONE=3, reachable hierarchically by benches.
REQ-015 In IDLE, a rising edge with start=1, abort=0 and reps!=0 SHALL do all of the following: capture pattern, reps and gap into internal registers; enter SEND; drive out=pattern[WIDTH-1], out_valid=1 and busy=1.
REQ-016 In IDLE, start=1 with reps=0 SHALL enter DONE directly, with no out_valid cycle.
REQ-017 In SEND, each cycle SHALL present one captured bit on out, MSB to LSB, with out_valid=1; each bit SHALL be held for exactly one cycle.
REQ-018 After the LSB is presented, the remaining-repetition count SHALL decrement; at 0 the block SHALL enter DONE.
REQ-019 If repetitions remain and the captured gap is 0, the block SHALL restart at the MSB on the next cycle, back-to-back.
REQ-020 If repetitions remain and the captured gap is nonzero, the block SHALL enter GAP for exactly gap cycles with out=0, out_valid=0 and busy=1, then resume SEND at the MSB.
REQ-021 DONE SHALL last one cycle with done=1, busy=0, out=0 and out_valid=0, then return to IDLE.
REQ-022 Total busy cycles SHALL equal reps*WIDTH + (reps-1)*gap.
REQ-023 start SHALL be ignored outside IDLE, including during DONE.
REQ-024 Changes on pattern, reps or gap after capture SHALL have no effect on the transmission in progress.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge with out, out_valid, busy and done all 0, and SHALL produce no done pulse.
REQ-026 abort SHALL take priority over a simultaneous start.
REQ-027 Outside SEND, out SHALL be 0.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force state=IDLE and out, out_valid, busy and done to 0, and clear all counters and captured registers.
REQ-029 Reset asserted mid-transmission SHALL discard that transmission; after release the block SHALL wait for a new start.
REQ-030 start sampled on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-031 The bench SHALL cover: pattern=1011, reps=1, gap=0, start pulse -> out=1,0,1,1 on 4 consecutive cycles with out_valid=1, then done=1 for one cycle with busy=0.
REQ-032 The bench SHALL cover: pattern=1011, reps=2, gap=2 -> out_valid pattern 1111 00 1111, busy high 10 cycles, out bits 1011 0 0 1011, single done.
REQ-033 The bench SHALL cover: reps=0, start -> state IDLE->DONE->IDLE, out_valid never high, done for one cycle.
REQ-034 The bench SHALL cover: reps=3, abort on the 2nd bit of the 2nd repetition -> next cycle state=IDLE, all outputs 0, no done pulse; a start 2 cycles later with pattern=1101 -> transmits 1,1,0,1.
REQ-035 The bench SHALL cover: start re-pulsed and pattern changed to 0000 during SEND of 1011 -> output unchanged (1011), no second transmission.
REQ-036 The bench SHALL cover: rst asserted between clock edges during GAP -> outputs drop to 0 before the next edge; with out/out_valid looped into the team's fsm 1011 detector, exactly one detection pulse is seen per completed repetition.
